// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between the MEM stage and data memory.
// Define STB_FWD_EN for load forwarding; otherwise matching loads stall.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   st_valid,
  input  logic [ADDR_W-1:0]      st_addr,
  input  logic [DATA_W-1:0]      st_data,
  output logic                   st_ready,
  output logic                   stall,
  input  logic                   ld_valid,
  input  logic [ADDR_W-1:0]      ld_addr,
  output logic                   fwd_hit,
  output logic [DATA_W-1:0]      fwd_data,
  output logic                   mem_w_en,
  output logic                   mem_r_en,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_st_value,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0]  vld_q;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PW-1:0]     head_q;
  logic [PW-1:0]     tail_q;
  logic [CW-1:0]     cnt_q;

  logic              push;
  logic              drain;
  logic              match;
  logic              ld_block;
  logic [PW-1:0]     idx;
`ifdef STB_FWD_EN
  logic [DATA_W-1:0] match_data;
`endif

  assign count    = cnt_q;
  assign empty    = (cnt_q == '0);
  assign st_ready = (cnt_q != CW'(DEPTH));
  assign push     = st_valid & st_ready;

  // Walk oldest to youngest so the last hit is the youngest entry.
  always_comb begin
    match = 1'b0;
    idx   = head_q;
`ifdef STB_FWD_EN
    match_data = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (vld_q[idx] &&
          addr_q[idx][ADDR_W-1:2] == ld_addr[ADDR_W-1:2]) begin
        match = 1'b1;
`ifdef STB_FWD_EN
        match_data = data_q[idx];
`endif
      end
    end
  end

`ifdef STB_FWD_EN
  assign ld_block = 1'b0;
  assign fwd_hit  = match;
  assign fwd_data = match_data;
`else
  assign ld_block = ld_valid & match;
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

  // A blocked load yields the port so the matching entry can drain.
  assign drain    = ~empty & (~ld_valid | ld_block);
  assign mem_r_en = ld_valid & ~ld_block;
  assign mem_w_en = drain;
  assign stall    = (st_valid & ~st_ready) | ld_block;

  always_comb begin
    mem_addr     = '0;
    mem_st_value = '0;
    if (mem_r_en) begin
      mem_addr = ld_addr;
    end else if (drain) begin
      mem_addr = addr_q[head_q];
    end
    if (drain) begin
      mem_st_value = data_q[head_q];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (push) begin
        vld_q[tail_q]  <= 1'b1;
        addr_q[tail_q] <= st_addr;
        data_q[tail_q] <= st_data;
        tail_q         <= tail_q + PW'(1);
      end
      if (drain) begin
        vld_q[head_q] <= 1'b0;
        head_q        <= head_q + PW'(1);
      end
      case ({push, drain})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer between the EXE/MEM pipeline register and the single-port data memory (64 words, byte window 1024..1279).
- Accepts stores in one cycle, parks them in a small in-order FIFO, and drains one store per cycle into the memory write port whenever the pipeline is not using the port for a load.
- Loads that hit a pending store take the youngest matching data from the buffer, so memory stays coherent from the pipeline's view.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, 2..16.
- DATA_W, 32, store data width.
- ADDR_W, 32, byte address width. Entries compare on addr[ADDR_W-1:2] (word granularity).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low.
- st_valid  in  1  store request from MEM stage (MEM_W_EN).
- st_addr  in  ADDR_W  store byte address (ALU result).
- st_data  in  DATA_W  store value.
- st_ready  out  1  buffer not full.
- stall  out  1  st_valid & ~st_ready; freezes the pipeline.
- ld_valid  in  1  load request from MEM stage (MEM_R_EN).
- ld_addr  in  ADDR_W  load byte address.
- fwd_hit  out  1  load address matches a buffered entry.
- fwd_data  out  DATA_W  data of the youngest matching entry; 0 when no hit.
- mem_w_en  out  1  data-memory write enable.
- mem_r_en  out  1  data-memory read enable.
- mem_addr  out  ADDR_W  data-memory address (ld_addr during a load, head address during a drain, else 0).
- mem_st_value  out  DATA_W  head entry data during a drain, else 0.
- count  out  $clog2(DEPTH)+1  occupancy.
- empty  out  1  count==0.

Behaviour:
- Storage: circular FIFO with DEPTH entries {valid, addr, data}, a head pointer, a tail pointer and a count register.
- Reset (rst low, async): all valid bits 0, pointers 0, count 0.
  - Outputs settle to st_ready=1, stall=0, fwd_hit=0, fwd_data=0, mem_w_en=0, mem_r_en=0, mem_addr=0, mem_st_value=0, empty=1.
  - Stores in flight are discarded.
- Enqueue: on a clk edge with st_valid & st_ready, the entry is written at tail, tail increments (wrapping at DEPTH), count increments.
  - A store is visible for forwarding/drain from the next cycle; there is no same-cycle bypass.
- Drain: the condition is drain = ~empty & ~ld_valid (combinational).
  - When drain: mem_w_en=1, mem_addr=head.addr, mem_st_value=head.data.
  - On the clock edge the memory writes; the head entry is invalidated, head increments and count decrements.
- Load: when ld_valid, mem_r_en=1 and mem_addr=ld_addr; no drain that cycle.
  - fwd_hit/fwd_data are purely combinational over all valid entries. The youngest match (the one closest to tail) wins.
  - The pipeline selects fwd_data over memory output when fwd_hit=1.
- Simultaneous enqueue and drain in one cycle: count is unchanged and both pointers advance.
- Full (count==DEPTH): st_ready=0.
  - A drain in the same cycle does not raise st_ready (no combinational path from ld_valid to st_ready). The store retries next cycle under stall.
- st_valid & ld_valid together is illegal upstream. If it occurs, the load owns the port and the store is enqueued normally if st_ready.
- Pointer wrap-around is at DEPTH-1 -> 0. count saturates at neither end because the guards prevent over/underflow.
- Addresses are passed through unmodified; range checking belongs to the memory.

Optional Feature:
- Macro STB_FWD_EN.
- Defined: load forwarding as above.
- Undefined: fwd_hit is forced to 0 and fwd_data to 0.
  - A load whose word address matches any valid entry raises stall and forces mem_r_en=0.
  - The drain is permitted that cycle, overriding ld_valid.
  - The load repeats until no entry matches, then proceeds to memory.

Test Plan:
- Reset mid-drain: fill 3 stores, assert rst low for 1 cycle -> count=0, empty=1, mem_w_en=0 immediately (async), no further writes occur.
- Single store/drain: store 0x400<=0xDEADBEEF, idle -> next cycle mem_w_en=1, mem_addr=0x400, mem_st_value=0xDEADBEEF; following cycle empty=1.
- Fill to full: 4 stores with ld_valid held high (no drain) -> count=4, st_ready=0; 5th store gives stall=1. Drop ld_valid -> drains in order 0x400,0x404,0x408,0x40C, then the 5th store is accepted.
- Youngest-wins forwarding (STB_FWD_EN): stores 0x410<=1 then 0x410<=2, hold ld_valid with ld_addr=0x410 -> fwd_hit=1, fwd_data=2. ld_addr=0x414 -> fwd_hit=0.
- Wrap-around: 10 alternating store/idle cycles -> pointers wrap past DEPTH-1, memory receives all 10 writes in order, count never exceeds 1.
- No-forward build (STB_FWD_EN undefined): store 0x420<=7, then load 0x420 -> stall=1, mem_r_en=0, drain writes 7. The next cycle stall=0 and mem_r_en=1 at 0x420.
